// File: rtl/fifo_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ram_ctrl_if
//
// Stream-side bundle of fifo_ram_ctrl: the producer (push) channel, the
// consumer (pop) channel, the fill level and a debug view of the output-buffer
// occupancy FSM.
//
// Handshake rule for both channels: a word moves on a rising clk edge exactly
// when valid and ready are both high in the cycle before that edge. The sender
// holds valid and data steady until the transfer happens. ready may depend
// combinationally on the current state. valid never depends on ready.
//
// Ports (names keep the controller's point of view: *_i enters the controller):
//   push_valid_i / push_ready_o / push_data_i : producer -> controller
//   pop_valid_o  / pop_ready_i  / pop_data_o  : controller -> consumer
//   count_o                                   : total words held
//   dbg_occ_o                                 : occupancy FSM state (0/1/2)
//
// Modports:
//   master : producer/consumer side (testbench or surrounding logic)
//   slave  : the controller itself
//
// CNT_WIDTH must equal $clog2(DATA_DEPTH+3) of the controller it is bound to.
// -----------------------------------------------------------------------------
interface fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 9
);

  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_data_i;

  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_data_o;

  logic [CNT_WIDTH-1:0]  count_o;
  logic [1:0]            dbg_occ_o;

  modport master (
    output push_valid_i,
    output push_data_i,
    output pop_ready_i,
    input  push_ready_o,
    input  pop_valid_o,
    input  pop_data_o,
    input  count_o,
    input  dbg_occ_o
  );

  modport slave (
    input  push_valid_i,
    input  push_data_i,
    input  pop_ready_i,
    output push_ready_o,
    output pop_valid_o,
    output pop_data_o,
    output count_o,
    output dbg_occ_o
  );

endinterface

// File: rtl/fifo_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ram_ctrl
//
// First-word-fall-through FIFO controller in front of an external dual-port RAM
// with one cycle of read latency. Words are written through RAM port A and read
// back through port B. A two-entry output buffer absorbs the read latency so
// pop_data_o comes straight from a register and one word per cycle can be
// popped continuously.
//
// Ports:
//   clk            : sole clock, all state changes on its rising edge
//   rst            : synchronous, active-high reset
//   bus (slave)    : push/pop stream channels, count_o and dbg_occ_o
//                    (see fifo_ram_ctrl_if for the valid/ready rule)
//   ram_wr_en_o    : RAM port A enable
//   ram_wr_we_o    : RAM port A write enable
//   ram_wr_addr_o  : RAM port A address
//   ram_wr_data_o  : RAM port A write data
//   ram_rd_en_o    : RAM port B read enable
//   ram_rd_addr_o  : RAM port B address
//   ram_rd_data_i  : RAM port B read data, valid the cycle after ram_rd_en_o
//
// Capacity is DATA_DEPTH words in RAM plus one read in flight plus two words
// in the output buffer; the read-issue rule guarantees that in-flight plus
// buffered never exceeds two, so count_o tops out at DATA_DEPTH+2.
// -----------------------------------------------------------------------------
module fifo_ram_ctrl #(
  parameter int DATA_DEPTH = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  fifo_ram_ctrl_if.slave                      bus,

  output logic                                ram_wr_en_o,
  output logic                                ram_wr_we_o,
  output logic [$clog2(DATA_DEPTH)-1:0]       ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]               ram_wr_data_o,

  output logic                                ram_rd_en_o,
  output logic [$clog2(DATA_DEPTH)-1:0]       ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]               ram_rd_data_i
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 3);
  // ram_cnt must represent 0..DATA_DEPTH inclusive.
  localparam int RAMC_WIDTH = ADDR_WIDTH + 1;
  localparam logic [RAMC_WIDTH-1:0] RAM_FULL = RAMC_WIDTH'(DATA_DEPTH);

  // Output-buffer occupancy. Encoding equals the number of buffered words so
  // it can be added directly into the fill level.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  occ_e                  occ_q;
  occ_e                  occ_d;
  logic                  head_q;          // index of the word at the pop port
  logic [DATA_WIDTH-1:0] ob_q [2];        // output buffer storage

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [RAMC_WIDTH-1:0] ram_cnt_q;       // words resident in RAM only
  logic                  inflight_q;      // a RAM read returns this cycle

  // ---------------------------------------------------------------------------
  // Handshake and control terms
  // ---------------------------------------------------------------------------
  logic       push_ready;
  logic       push_fire;
  logic       pop_valid;
  logic       pop_fire;
  logic       capture;
  logic       rd_issue;
  logic [2:0] slots;
  logic       tail;

  assign push_ready = !rst && (ram_cnt_q != RAM_FULL);
  assign push_fire  = bus.push_valid_i && push_ready;
  assign pop_fire   = pop_valid && bus.pop_ready_i;

  // The word coming back from RAM this cycle lands in the buffer.
  assign capture    = inflight_q;

  // Buffer positions that will be taken after this edge: words already
  // buffered plus the one arriving, minus the one leaving. A new read is only
  // issued while that leaves room, which is what makes a capture in TWO
  // impossible. Including pop_fire keeps back-to-back pops bubble-free and is
  // why pop_ready_i reaches ram_rd_en_o combinationally.
  assign slots      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_fire};
  assign rd_issue   = !rst && (ram_cnt_q != '0) && (slots < 3'd2);

  // Next free buffer position: head when empty, the other entry when one word
  // is held. In TWO there is never a capture, so the value is unused there.
  assign tail       = head_q ^ (occ_q == OCC_ONE);

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (capture) begin
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (capture && !pop_fire) begin
          occ_d = OCC_TWO;
        end else if (!capture && pop_fire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop_fire) begin
          occ_d = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pop_valid     = (occ_q != OCC_EMPTY);
    bus.dbg_occ_o = occ_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: pointers, RAM fill, in-flight flag, buffer storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      ob_q[0]    <= '0;
      ob_q[1]    <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end

      case ({push_fire, rd_issue})
        2'b10:   ram_cnt_q <= ram_cnt_q + RAMC_WIDTH'(1);
        2'b01:   ram_cnt_q <= ram_cnt_q - RAMC_WIDTH'(1);
        default: ram_cnt_q <= ram_cnt_q;
      endcase

      inflight_q <= rd_issue;

      if (capture) begin
        ob_q[tail] <= ram_rd_data_i;
      end
      if (pop_fire) begin
        head_q <= ~head_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Write port follows the push handshake directly; the write data is passed
  // through unconditionally and qualified by the enable.
  assign ram_wr_en_o   = push_fire;
  assign ram_wr_we_o   = push_fire;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_wr_data_o = bus.push_data_i;

  assign ram_rd_en_o   = rd_issue;
  assign ram_rd_addr_o = rd_ptr_q;

  assign bus.push_ready_o = push_ready;
  assign bus.pop_valid_o  = pop_valid;
  assign bus.pop_data_o   = ob_q[head_q];
  assign bus.count_o      = CNT_WIDTH'(ram_cnt_q) + CNT_WIDTH'(occ_q)
                          + CNT_WIDTH'(inflight_q);

endmodule
